// File: rtl/pyjamask96_dec.sv
// pyjamask96_dec: byte-serial Pyjamask-96 block decryption core.
// Ciphertext and key are shifted in a byte per cycle, the forward key
// schedule fills a round-key store, then the inverse rounds run one
// step per cycle and the plaintext is streamed out a byte per cycle.
module pyjamask96_dec #(
  parameter int NB_ROUNDS = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic [7:0] byte_key_in,
  output logic       busy,
  output logic       valid,
  output logic [7:0] byte_out
);

  localparam int NB_RK = NB_ROUNDS + 1;

  localparam logic [31:0] COL_KS     = 32'hb881b9ca;
  localparam logic [31:0] COL_INV_M0 = 32'h2037a121;
  localparam logic [31:0] COL_INV_M1 = 32'h108ff2a0;
  localparam logic [31:0] COL_INV_M2 = 32'h9054d8c0;

  typedef enum logic [2:0] {
    IDLE, LOAD, KEY_EXP, ADD_LAST, INV_MIX, INV_SUB, ADD_RK, OUT
  } fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [95:0]  state_reg;
  logic [127:0] key_reg;
  logic [95:0]  rk_mem [NB_RK];
  logic [4:0]   count_reg;
  logic [3:0]   round_reg;
  logic         busy_reg, busy_next;
  logic         valid_reg, valid_next;
  logic [7:0]   byte_out_reg, byte_out_next;

  // Circulant matrix times vector: MSB of vec selects the first column,
  // each lower bit selects the column rotated right by one more place.
  function automatic logic [31:0] mat_mult(input logic [31:0] col, input logic [31:0] vec);
    logic [31:0] res;
    logic [31:0] c;
    res = '0;
    c   = col;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) res = res ^ c;
      c = {c[0], c[31:1]};
    end
    return res;
  endfunction

  // One forward key-schedule round on the four 32-bit key rows.
  function automatic logic [127:0] ks_round(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] k0, k1, k2, k3, t;
    k0 = k[127:96];
    k1 = k[95:64];
    k2 = k[63:32];
    k3 = k[31:0];
    t  = k0 ^ k1 ^ k2 ^ k3;
    k0 = k0 ^ t;
    k1 = k1 ^ t;
    k2 = k2 ^ t;
    k3 = k3 ^ t;
    k0 = mat_mult(COL_KS, k0);
    k1 = {k1[23:0], k1[31:24]};
    k2 = {k2[16:0], k2[31:17]};
    k3 = {k3[13:0], k3[31:14]};
    k0 = k0 ^ 32'h0000_0080 ^ {28'd0, r};
    k1 = k1 ^ 32'h0000_6a00;
    k2 = k2 ^ 32'h003f_0000;
    k3 = k3 ^ 32'h2400_0000;
    return {k0, k1, k2, k3};
  endfunction

  // Inverse of the 3-bit S-box; bit 2 is row 0.
  function automatic logic [2:0] inv_sbox(input logic [2:0] x);
    logic [2:0] y;
    case (x)
      3'd0:    y = 3'd7;
      3'd1:    y = 3'd0;
      3'd2:    y = 3'd4;
      3'd3:    y = 3'd1;
      3'd4:    y = 3'd5;
      3'd5:    y = 3'd3;
      3'd6:    y = 3'd2;
      default: y = 3'd6;
    endcase
    return y;
  endfunction

  logic [127:0] ks_next;
  logic [95:0]  mix_out;
  logic [95:0]  sub_out;
  logic [7:0]   state_bytes [12];
  logic [3:0]   rk_raddr;
  logic [95:0]  rk_rdata;
  logic         load_take;
  logic         start_take;

  assign ks_next = ks_round(key_reg, round_reg);

  assign mix_out = {mat_mult(COL_INV_M0, state_reg[95:64]),
                    mat_mult(COL_INV_M1, state_reg[63:32]),
                    mat_mult(COL_INV_M2, state_reg[31:0])};

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_inv_sub
      logic [2:0] col_out;
      assign col_out         = inv_sbox({state_reg[64+gi], state_reg[32+gi], state_reg[gi]});
      assign sub_out[64+gi]  = col_out[2];
      assign sub_out[32+gi]  = col_out[1];
      assign sub_out[gi]     = col_out[0];
    end
    for (gi = 0; gi < 12; gi++) begin : g_bytes
      assign state_bytes[gi] = state_reg[95-8*gi -: 8];
    end
  endgenerate

  // The last round key is only needed in ADD_LAST; otherwise the round counter addresses.
  assign rk_raddr = (fsm_reg == ADD_LAST) ? 4'(NB_ROUNDS) : round_reg;
  assign rk_rdata = rk_mem[rk_raddr];

  // Start only counts once all 16 bytes are in; load is dead at that point, so start wins.
  assign start_take = start && (fsm_reg == LOAD) && (count_reg == 5'd16);
  assign load_take  = load && ((fsm_reg == IDLE) || ((fsm_reg == LOAD) && (count_reg < 5'd16)));

  assign busy     = busy_reg;
  assign valid    = valid_reg;
  assign byte_out = byte_out_reg;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_reg <= IDLE;
    else       fsm_reg <= fsm_next;
  end

  // Next-state and next-output logic.
  always_comb begin
    fsm_next      = fsm_reg;
    busy_next     = busy_reg;
    valid_next    = 1'b0;
    byte_out_next = 8'h00;
    case (fsm_reg)
      IDLE:     if (load) fsm_next = LOAD;
      LOAD: begin
        if (start_take) begin
          fsm_next  = KEY_EXP;
          busy_next = 1'b1;
        end
      end
      KEY_EXP:  if (round_reg == 4'(NB_ROUNDS - 1)) fsm_next = ADD_LAST;
      ADD_LAST: fsm_next = INV_MIX;
      INV_MIX:  fsm_next = INV_SUB;
      INV_SUB:  fsm_next = ADD_RK;
      ADD_RK:   fsm_next = (round_reg == 4'd0) ? OUT : INV_MIX;
      OUT: begin
        if (count_reg < 5'd12) begin
          valid_next    = 1'b1;
          byte_out_next = state_bytes[count_reg[3:0]];
        end else begin
          fsm_next  = IDLE;
          busy_next = 1'b0;
        end
      end
      default:  fsm_next = IDLE;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      byte_out_reg <= 8'h00;
    end else begin
      busy_reg     <= busy_next;
      valid_reg    <= valid_next;
      byte_out_reg <= byte_out_next;
    end
  end

  // Datapath: byte loading, key schedule, inverse rounds and output indexing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= '0;
      key_reg   <= '0;
      count_reg <= '0;
      round_reg <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (load_take) begin
            key_reg   <= {key_reg[119:0], byte_key_in};
            state_reg <= {state_reg[87:0], byte_in};
            count_reg <= 5'd1;
          end
        end
        LOAD: begin
          if (start_take) begin
            round_reg <= 4'd0;
          end else if (load_take) begin
            key_reg <= {key_reg[119:0], byte_key_in};
            if (count_reg < 5'd12) state_reg <= {state_reg[87:0], byte_in};
            count_reg <= count_reg + 5'd1;
          end
        end
        KEY_EXP: begin
          key_reg <= ks_next;
          // Hold at the last round so the inverse rounds start from it.
          if (round_reg != 4'(NB_ROUNDS - 1)) round_reg <= round_reg + 4'd1;
        end
        ADD_LAST: state_reg <= state_reg ^ rk_rdata;
        INV_MIX:  state_reg <= mix_out;
        INV_SUB:  state_reg <= sub_out;
        ADD_RK: begin
          state_reg <= state_reg ^ rk_rdata;
          if (round_reg != 4'd0) round_reg <= round_reg - 4'd1;
          else                   count_reg <= 5'd0;
        end
        OUT: begin
          if (count_reg < 5'd12) count_reg <= count_reg + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Round-key store: RK0 on start, RK1..RKn one per key-schedule cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB_RK; i++) rk_mem[i] <= '0;
    end else if (start_take) begin
      rk_mem[0] <= key_reg[127:32];
    end else if (fsm_reg == KEY_EXP) begin
      rk_mem[round_reg + 4'd1] <= ks_next[127:32];
    end
  end

endmodule

// File: tb/tb_pyjamask96_dec.sv
// tb_pyjamask96_dec: directed bench for the Pyjamask-96 decryption core.
// Plaintexts are encrypted by a forward model here, the ciphertext is
// decrypted by the core, and the output is checked against a scoreboard.
module tb_pyjamask96_dec;

  logic       clk;
  logic       reset;
  logic       load;
  logic       start;
  logic [7:0] byte_in;
  logic [7:0] byte_key_in;
  logic       busy;
  logic       valid;
  logic [7:0] byte_out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] sb_q [$];

  pyjamask96_dec #(.NB_ROUNDS(14)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .start(start),
    .byte_in(byte_in),
    .byte_key_in(byte_key_in),
    .busy(busy),
    .valid(valid),
    .byte_out(byte_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- forward reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_mult(input logic [31:0] col, input logic [31:0] v);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++)
      if (v[i]) acc = acc ^ rotr(col, 31 - i);
    return acc;
  endfunction

  function automatic logic [2:0] m_sbox(input logic [2:0] x);
    logic [2:0] y;
    case (x)
      3'd0: y = 3'd1;  3'd1: y = 3'd3;  3'd2: y = 3'd6;  3'd3: y = 3'd5;
      3'd4: y = 3'd2;  3'd5: y = 3'd4;  3'd6: y = 3'd7;  default: y = 3'd0;
    endcase
    return y;
  endfunction

  function automatic logic [95:0] m_sub(input logic [95:0] s);
    logic [95:0] o;
    logic [2:0]  y;
    o = '0;
    for (int j = 0; j < 32; j++) begin
      y = m_sbox({s[64+j], s[32+j], s[j]});
      o[64+j] = y[2];
      o[32+j] = y[1];
      o[j]    = y[0];
    end
    return o;
  endfunction

  function automatic logic [127:0] m_ks(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = w0 ^ w1 ^ w2 ^ w3;
    w0 = m_mult(32'hb881b9ca, w0 ^ t);
    w1 = rotl(w1 ^ t, 8);
    w2 = rotl(w2 ^ t, 15);
    w3 = rotl(w3 ^ t, 18);
    w0 = w0 ^ (32'h80 ^ 32'(r));
    w1 = w1 ^ 32'h0000_6a00;
    w2 = w2 ^ 32'h003f_0000;
    w3 = w3 ^ 32'h2400_0000;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [95:0] m_enc(input logic [95:0] pt, input logic [127:0] key);
    logic [95:0]  s;
    logic [127:0] k;
    s = pt;
    k = key;
    for (int r = 0; r < 14; r++) begin
      s = s ^ k[127:32];
      s = m_sub(s);
      s = {m_mult(32'ha3861085, s[95:64]), m_mult(32'h63417021, s[63:32]),
           m_mult(32'h692cf280, s[31:0])};
      k = m_ks(k, r);
    end
    return s ^ k[127:32];
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives bytes first..first+n-1 of ct/key; bytes past the block are junk.
  task automatic load_seq(input logic [95:0] ct, input logic [127:0] key,
                          input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      load = 1'b1;
      if (i < 12) byte_in = ct[95-8*i -: 8];
      else        byte_in = 8'($urandom);
      if (i < 16) byte_key_in = key[127-8*i -: 8];
      else        byte_key_in = 8'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  // Pulses start, then watches the output window; k counts edges after the start edge.
  task automatic run_op(input string tag, input bit poke, input bit zero_case,
                        input logic [95:0] ct, input logic [127:0] key);
    int first_k, last_k, n_valid;
    logic [95:0] got;
    logic [7:0]  exp_b;
    first_k = -1; last_k = -1; n_valid = 0; got = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1);
    for (int k = 1; k <= 75; k++) begin
      if (poke && (k == 2 || k == 17 || k == 40 || k == 58 || k == 63)) begin
        load = 1'b1; start = 1'b1;
        byte_in = 8'($urandom); byte_key_in = 8'($urandom);
      end else begin
        load = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      if (valid === 1'b1) begin
        n_valid++;
        if (first_k < 0) first_k = k;
        last_k = k;
        got = {got[87:0], byte_out};
        if (!zero_case && sb_q.size() > 0) begin
          exp_b = sb_q.pop_front();
          check({tag, "_byte"}, byte_out, exp_b);
        end
      end
    end
    load = 1'b0; start = 1'b0;
    check({tag, "_first_cycle"}, first_k, 58);
    check({tag, "_last_cycle"}, last_k, 69);
    check({tag, "_n_valid"}, n_valid, 12);
    check({tag, "_sb_drained"}, sb_q.size(), 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, valid, 0);
    check({tag, "_byte_end"}, byte_out, 0);
    if (zero_case) check({tag, "_reenc"}, m_enc(got, key), ct);
    $display("%s: ct=%h out=%h first=%0d n=%0d", tag, ct, got, first_k, n_valid);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] key;
    logic [95:0]  pt, ct;
    int nv;
    reset = 1'b1; load = 1'b0; start = 1'b0; byte_in = '0; byte_key_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_byte", byte_out, 0);
    reset = 1'b0;
    @(negedge clk);

    // All-zero key and ciphertext; output must re-encrypt to zero.
    load_seq(96'h0, 128'h0, 0, 16);
    run_op("zero", 1'b0, 1'b1, 96'h0, 128'h0);

    // Round trips with premature start, extra loads and busy-time pokes mixed in.
    for (int t = 0; t < 12; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom};
      ct  = m_enc(pt, key);
      for (int i = 0; i < 12; i++) sb_q.push_back(pt[95-8*i -: 8]);
      if (t == 0) begin
        load_seq(ct, key, 0, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("premature_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("premature_busy_later", busy, 0);
        load_seq(ct, key, 10, 6);
      end else if (t == 1) begin
        load_seq(ct, key, 0, 20);
      end else begin
        load_seq(ct, key, 0, 16);
      end
      run_op($sformatf("rt%0d", t), (t == 2 || t == 3), 1'b0, ct, key);
    end

    // Reset mid-round, then mid-output.
    for (int t = 0; t < 2; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom};
      load_seq(ct, key, 0, 16);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat ((t == 0) ? 30 : 60) @(negedge clk);
      check($sformatf("abort%0d_busy_before", t), busy, 1);
      check($sformatf("abort%0d_valid_before", t), valid, (t == 1));
      reset = 1'b1;
      #1;
      check($sformatf("abort%0d_busy", t), busy, 0);
      check($sformatf("abort%0d_valid", t), valid, 0);
      check($sformatf("abort%0d_byte", t), byte_out, 0);
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      repeat (80) begin
        @(negedge clk);
        if (valid === 1'b1) nv++;
      end
      check($sformatf("abort%0d_no_valid", t), nv, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("abort%0d_start_no_load", t), busy, 0);
      $display("abort%0d: reset applied, valid pulses afterwards=%0d", t, nv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pyjamask96_dec.md
PYJAMASK96_DEC -- requirements
Module: pyjamask96_dec

Interface
REQ-001 SHALL have parameter NB_ROUNDS, default 14, giving the Pyjamask-96 round count.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port load, input, 1 bit: while high, one ciphertext byte and one key byte are shifted in per cycle.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins decryption.
REQ-006 SHALL have port byte_in, input, 8 bits: ciphertext byte, MSB-first (byte 0 = bits 95:88).
REQ-007 SHALL have port byte_key_in, input, 8 bits: key byte, MSB-first (byte 0 = bits 127:120).
REQ-008 SHALL have port busy, output, 1 bit: high from start acceptance until the last output byte.
REQ-009 SHALL have port valid, output, 1 bit: byte_out holds a plaintext byte.
REQ-010 SHALL have port byte_out, output, 8 bits: plaintext byte, MSB-first.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, KEY_EXP, ADD_LAST, INV_MIX, INV_SUB, ADD_RK, OUT.
REQ-012 SHALL leave IDLE for LOAD on load=1, clearing the 5-bit byte counter; in IDLE and LOAD, each cycle with load=1 shifts byte_key_in into key (left 8), shifts byte_in into state only while count<12, and increments count up to a saturation value of 16.
REQ-013 SHALL ignore load once count=16, and SHALL ignore start while count<16; neither case raises an error.
REQ-014 SHALL accept start only in LOAD with count=16; when start and load are high together, start wins and the load byte is discarded.
REQ-015 SHALL write round key RK0 = key[127:32] (rows k0,k1,k2) into a 15x96-bit round-key store on start acceptance.
REQ-016 SHALL run the forward key schedule in KEY_EXP for exactly NB_ROUNDS cycles, storing RK1..RK14, one per cycle.
REQ-017 The key schedule round r (r = 0..13) SHALL perform, in order:
  - t = k0^k1^k2^k3, then each ki ^= t;
  - k0 = circulant mult by column 0xb881b9ca;
  - k1 = ROTL32(k1,8), k2 = ROTL32(k2,15), k3 = ROTL32(k3,18);
  - k0 ^= 0x00000080^r, k1 ^= 0x00006a00, k2 ^= 0x003f0000, k3 ^= 0x24000000.
REQ-018 SHALL perform state ^= RK14 in ADD_LAST, taking 1 cycle.
REQ-019 SHALL execute, for r = 13 down to 0, one cycle each of INV_MIX, INV_SUB and ADD_RK (state ^= RKr), in that order; the 4-bit round counter decrements after ADD_RK.
REQ-020 INV_MIX SHALL multiply rows 0/1/2 by the circulant matrices with first columns 0x2037a121 / 0x108ff2a0 / 0x9054d8c0.
REQ-021 INV_SUB SHALL apply, per bit column j, to the 3-bit value (row0[j],row1[j],row2[j]) the inverse S-box {7,0,4,1,5,3,2,6}.
REQ-022 After ADD_RK with r=0, the FSM SHALL enter OUT and drive valid=1 for exactly 12 consecutive cycles, presenting byte_out = state bytes 0..11 in order.
REQ-023 The first valid byte SHALL appear 58 cycles after the start-accepting edge; the total start-to-last-byte time SHALL be 69 cycles.
REQ-024 After the 12th byte, the FSM SHALL return to IDLE with busy=0 and valid=0 on the next edge; byte_out SHALL then read 0.
REQ-025 load and start SHALL be ignored from start acceptance until IDLE is reached.
REQ-026 All arithmetic SHALL be GF(2) only; rotations are modulo 32; the round counter never wraps below 0.

Reset
REQ-027 On reset=1, asynchronously: FSM=IDLE; state, key, round-key store, byte and round counters = 0; busy=0, valid=0, byte_out=8'h00.
REQ-028 Reset asserted mid-load, mid-round or mid-OUT SHALL abort the operation with no further valid bytes emitted; a fresh full load is then required.

Verification
REQ-029 Reset: assert reset mid-round -> busy=0, valid=0 and byte_out=00 within the same cycle; no valid pulse follows.
REQ-030 Round trip: encrypt 12 random plaintexts with the C reference pyjamask_96_enc, load key and ciphertext, start -> byte_out equals plaintext, and valid high exactly 12 cycles, first byte at cycle 58.
REQ-031 All-zero key and ciphertext -> output matches the C reference pyjamask_96_dec, byte for byte.
REQ-032 Premature start after 10 bytes -> start ignored, busy stays 0; after 6 more bytes, start is accepted.
REQ-033 Extra loads: 20 load cycles -> only the first 16 key bytes and 12 ciphertext bytes are used, and the result is unchanged.
REQ-034 load and start pulsed while busy -> no effect on the output bytes or their timing.
